// File: rtl/vram_arbiter.sv
// Frame-buffer arbiter: display reads from the front bank, queued writes drain to the back bank
// during blanking, and the banks swap on the vsync falling edge. VRAM_STATS_EN adds counters.
module vram_arbiter #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned PIX_AW   = 19,
  parameter int unsigned WQ_DEPTH = 4
) (
  input  logic              vga_clk,
  input  logic              clrn,
  input  logic [10:0]       col_addr,
  input  logic [10:0]       row_addr,
  input  logic              hs_in,
  input  logic              vs_in,
  output logic              hs_out,
  output logic              vs_out,
  output logic [11:0]       pix_out,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [PIX_AW-1:0] wr_addr,
  input  logic [11:0]       wr_data,
  input  logic              swap_req,
  output logic              swap_done,
  output logic              front_bank,
  output logic [PIX_AW:0]   mem_addr,
  output logic              mem_we,
  output logic [11:0]       mem_wdata,
  input  logic [11:0]       mem_rdata,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       frame_cnt
);

  localparam int unsigned QAW = $clog2(WQ_DEPTH);
  localparam logic [QAW:0] QFull = (QAW+1)'(WQ_DEPTH);

  typedef enum logic [0:0] {StIdle, StPend} swap_st_e;

  logic              disp_act;
  logic [PIX_AW-1:0] rd_pix;
  logic              hs_q, vs_q, act_q;
  logic              vs_fall;

  logic [PIX_AW-1:0] q_addr [WQ_DEPTH];
  logic [11:0]       q_data [WQ_DEPTH];
  logic [QAW-1:0]    wptr_q, rptr_q;
  logic [QAW:0]      cnt_q, cnt_d;
  logic              ready_q;
  logic              push, pop, fifo_empty;

  swap_st_e          state_q, state_d;
  logic              swap_fire;
  logic              front_q, done_q;

  assign disp_act   = (col_addr < 11'(H_ACTIVE)) && (row_addr < 11'(V_ACTIVE));
  assign rd_pix     = PIX_AW'(row_addr) * PIX_AW'(H_ACTIVE) + PIX_AW'(col_addr);
  assign vs_fall    = vs_q & ~vs_in;
  assign fifo_empty = (cnt_q == '0);
  assign push       = wr_valid & ready_q;
  assign pop        = ~disp_act & ~fifo_empty;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!push && pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (push) begin
      q_addr[wptr_q] <= wr_addr;
      q_data[wptr_q] <= wr_data;
    end
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      act_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      front_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      hs_q    <= hs_in;
      vs_q    <= vs_in;
      act_q   <= disp_act;
      if (push) wptr_q <= wptr_q + QAW'(1);
      if (pop)  rptr_q <= rptr_q + QAW'(1);
      cnt_q   <= cnt_d;
      ready_q <= (cnt_d != QFull);
      front_q <= front_q ^ swap_fire;
      done_q  <= swap_fire;
    end
  end

  // Swap FSM: state register
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (swap_req) state_d = StPend;
      StPend:  if (vs_fall && fifo_empty) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // A pending swap waits for a vsync edge with no queued writes left for the old back bank
  always_comb begin
    swap_fire = (state_q == StPend) && vs_fall && fifo_empty;
  end

  // Display always owns the port when active; memory outputs read as zero while in reset
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (clrn) begin
      if (disp_act) begin
        mem_addr = {front_q, rd_pix};
      end else if (pop) begin
        mem_addr  = {~front_q, q_addr[rptr_q]};
        mem_we    = 1'b1;
        mem_wdata = q_data[rptr_q];
      end
    end
  end

  assign hs_out     = hs_q;
  assign vs_out     = vs_q;
  assign pix_out    = act_q ? mem_rdata : 12'h000;
  assign wr_ready   = ready_q;
  assign swap_done  = done_q;
  assign front_bank = front_q;

`ifdef VRAM_STATS_EN
  logic [15:0] stall_q, frame_q;

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      stall_q <= '0;
      frame_q <= '0;
    end else begin
      if (wr_valid && !ready_q && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      if (vs_fall) frame_q <= frame_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign frame_cnt = frame_q;
`else
  assign stall_cnt = '0;
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: drivers push expectations into queues, a negedge monitor
// pops and compares whenever the DUT reads, writes or swaps.
module tb_vram_arbiter;

  logic        vga_clk = 1'b0;
  logic        clrn;
  logic [10:0] col_addr, row_addr;
  logic        hs_in, vs_in, hs_out, vs_out;
  logic [11:0] pix_out;
  logic        wr_valid, wr_ready;
  logic [18:0] wr_addr;
  logic [11:0] wr_data;
  logic        swap_req, swap_done, front_bank;
  logic [19:0] mem_addr;
  logic        mem_we;
  logic [11:0] mem_wdata, mem_rdata;
  logic [15:0] stall_cnt, frame_cnt;

  always #5 vga_clk = ~vga_clk;

  vram_arbiter dut (
    .vga_clk    (vga_clk),
    .clrn       (clrn),
    .col_addr   (col_addr),
    .row_addr   (row_addr),
    .hs_in      (hs_in),
    .vs_in      (vs_in),
    .hs_out     (hs_out),
    .vs_out     (vs_out),
    .pix_out    (pix_out),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .swap_req   (swap_req),
    .swap_done  (swap_done),
    .front_bank (front_bank),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .stall_cnt  (stall_cnt),
    .frame_cnt  (frame_cnt)
  );

  // Memory model: read data is the low 12 bits of the previous address
  always @(posedge vga_clk) mem_rdata <= mem_addr[11:0];

  int unsigned cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_evt(input string name, input logic [31:0] act);
    checks++;
    $display("FAIL %s: got %0h expected no event (cycle %0d)", name, act, cyc);
  endtask

  logic [19:0]  rd_q[$];
  logic [11:0]  pix_q[$];
  logic [31:0]  wr_q[$];
  int unsigned  sw_cyc_q[$];
  logic         sw_bank_q[$];
  logic         exp_rd  = 1'b0;
  logic         prev_rd = 1'b0;

  always @(negedge vga_clk) begin
    if (clrn) begin
      if (exp_rd) begin
        if (rd_q.size() == 0) fail_evt("rd_unexpected", 32'(mem_addr));
        else chk("rd_addr", 32'(mem_addr), 32'(rd_q.pop_front()));
      end
      if (prev_rd) begin
        if (pix_q.size() == 0) fail_evt("pix_unexpected", 32'(pix_out));
        else chk("pix", 32'(pix_out), 32'(pix_q.pop_front()));
      end else begin
        chk("pix_blank", 32'(pix_out), 32'd0);
      end
      if (mem_we) begin
        chk("we_while_active", 32'(exp_rd), 32'd0);
        if (wr_q.size() == 0) fail_evt("wr_unexpected", {mem_addr, mem_wdata});
        else chk("wr", {mem_addr, mem_wdata}, wr_q.pop_front());
      end
      if (swap_done) begin
        if (sw_cyc_q.size() == 0) fail_evt("swap_unexpected", 32'(front_bank));
        else begin
          chk("swap_cycle", cyc, sw_cyc_q.pop_front());
          chk("swap_bank", 32'(front_bank), 32'(sw_bank_q.pop_front()));
        end
      end
    end
    prev_rd = clrn && exp_rd;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge vga_clk);
    #1;
    swap_req = 1'b0;
  endtask

  task automatic set_blank();
    col_addr = 11'd700;
    row_addr = 11'd0;
    exp_rd   = 1'b0;
  endtask

  task automatic act(input int r, input int c, input logic bank, input logic [11:0] px);
    col_addr = 11'(c);
    row_addr = 11'(r);
    exp_rd   = 1'b1;
    rd_q.push_back({bank, 19'(r * 640 + c)});
    pix_q.push_back(px);
  endtask

  task automatic wpush(input int a, input logic [11:0] d, input logic bank, input logic expect_it);
    wr_valid = 1'b1;
    wr_addr  = 19'(a);
    wr_data  = d;
    if (expect_it) wr_q.push_back({bank, 19'(a), d});
  endtask

  task automatic expect_swap(input logic bank);
    sw_cyc_q.push_back(cyc + 1);
    sw_bank_q.push_back(bank);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_hs_out"}, 32'(hs_out), 32'd1);
    chk({tag, "_vs_out"}, 32'(vs_out), 32'd1);
    chk({tag, "_pix_out"}, 32'(pix_out), 32'd0);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
    chk({tag, "_swap_done"}, 32'(swap_done), 32'd0);
    chk({tag, "_front_bank"}, 32'(front_bank), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  initial begin
    clrn = 1'b1; hs_in = 1'b1; vs_in = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    swap_req = 1'b0;
    set_blank();
    #2 clrn = 1'b0;
    step(); step();
    reset_checks("por");
    clrn = 1'b1;
    step();

    // Display reads, including the frame corners and both blank boundaries
    act(0, 0, 1'b0, 12'h000);     step();
    act(2, 3, 1'b0, 12'h503);     step();
    act(2, 4, 1'b0, 12'h504);     step();
    act(2, 5, 1'b0, 12'h505);     step();
    act(479, 639, 1'b0, 12'hFFF); step();
    col_addr = 11'd640; row_addr = 11'd0; exp_rd = 1'b0; hs_in = 1'b0; step();
    chk("hs_out_delay", 32'(hs_out), 32'd0);
    hs_in = 1'b1;
    col_addr = 11'd0; row_addr = 11'd480; step();
    set_blank(); step();

    // Four writes during active video fill the FIFO; a fifth is refused
    for (int i = 0; i < 4; i++) begin
      act(1, i, 1'b0, 12'(12'h280 + i));
      wpush(10 + i, 12'(12'hA01 + i), 1'b1, 1'b1);
      step();
    end
    chk("wr_ready_full", 32'(wr_ready), 32'd0);
    act(1, 4, 1'b0, 12'h284);
    wpush(99, 12'hFFF, 1'b1, 1'b0);
    step();
    wr_valid = 1'b0;
    set_blank(); step();
    chk("wr_ready_reopen", 32'(wr_ready), 32'd1);
    wpush(14, 12'hA05, 1'b1, 1'b1);   // push and pop in the same cycle
    step();
    wr_valid = 1'b0;
    repeat (5) step();

    // Mid-frame swap with an empty FIFO; a second request while pending is absorbed
    act(3, 0, 1'b0, 12'h780); swap_req = 1'b1; step();
    act(3, 1, 1'b0, 12'h781); swap_req = 1'b1; step();
    set_blank(); step(); step();
    vs_in = 1'b0; expect_swap(1'b1); step();
    step();
    vs_in = 1'b1; step(); step();
    chk("front_after_swap", 32'(front_bank), 32'd1);
    act(0, 0, 1'b1, 12'h000); step();
    act(0, 1, 1'b1, 12'h001); step();
    set_blank(); step();
    vs_in = 1'b0; step();
    vs_in = 1'b1; step(); step();
    chk("no_double_swap", 32'(front_bank), 32'd1);

    // Request coinciding with the vsync edge is deferred to the next frame
    vs_in = 1'b0; swap_req = 1'b1; step();
    vs_in = 1'b1; step(); step();
    chk("swap_same_edge_deferred", 32'(front_bank), 32'd1);
    vs_in = 1'b0; expect_swap(1'b0); step();
    vs_in = 1'b1; step(); step();
    chk("front_after_deferred", 32'(front_bank), 32'd0);

    // Swap held off by queued writes until they drain
    act(4, 0, 1'b0, 12'hA00); wpush(20, 12'hB01, 1'b1, 1'b1); step();
    act(4, 1, 1'b0, 12'hA01); wpush(21, 12'hB02, 1'b1, 1'b1); swap_req = 1'b1; step();
    wr_valid = 1'b0;
    act(4, 2, 1'b0, 12'hA02); vs_in = 1'b0; step();
    act(4, 3, 1'b0, 12'hA03); vs_in = 1'b1; step();
    set_blank(); step(); step(); step();
    chk("swap_held_fifo", 32'(front_bank), 32'd0);
    vs_in = 1'b0; expect_swap(1'b1); step();
    vs_in = 1'b1; step(); step();
    chk("front_after_held", 32'(front_bank), 32'd1);
    act(5, 0, 1'b1, 12'hC80); step();
    set_blank(); step();

    // Reset mid-line with queued writes and a pending swap
    hs_in = 1'b0;
    act(6, 0, 1'b1, 12'hF00); wpush(30, 12'hC01, 1'b0, 1'b0); step();
    act(6, 1, 1'b1, 12'hF01); wpush(31, 12'hC02, 1'b0, 1'b0); step();
    act(6, 2, 1'b1, 12'hF02); wpush(32, 12'hC03, 1'b0, 1'b0); swap_req = 1'b1; step();
    wr_valid = 1'b0;
    col_addr = 11'd3; row_addr = 11'd6; exp_rd = 1'b0;
    #5 clrn = 1'b0;
    #1 hs_in = 1'b1;
    reset_checks("mid_rst");
    set_blank(); step(); step();
    clrn = 1'b1; step();
    chk("front_after_rst", 32'(front_bank), 32'd0);
    repeat (4) step();
    act(0, 2, 1'b0, 12'h002); step();
    set_blank(); wpush(40, 12'hD01, 1'b1, 1'b1); step();
    wr_valid = 1'b0;
    repeat (3) step();
    vs_in = 1'b0; step();
    vs_in = 1'b1; step(); step();
    chk("no_stale_swap", 32'(front_bank), 32'd0);

`ifdef VRAM_STATS_EN
    clrn = 1'b0; step();
    clrn = 1'b1; step();
    for (int i = 0; i < 4; i++) begin
      act(0, i, 1'b0, 12'(i));
      wpush(50 + i, 12'(12'hE01 + i), 1'b1, 1'b1);
      step();
    end
    for (int i = 0; i < 100; i++) begin
      act(0, 4 + i, 1'b0, 12'(4 + i));
      wpush(99, 12'hFFF, 1'b1, 1'b0);
      step();
    end
    wr_valid = 1'b0;
    chk("stall_cnt", 32'(stall_cnt), 32'd100);
    set_blank();
    repeat (6) step();
    for (int f = 0; f < 3; f++) begin
      vs_in = 1'b0; step();
      vs_in = 1'b1; step();
    end
    step();
    chk("frame_cnt", 32'(frame_cnt), 32'd3);
`else
    chk("stall_cnt_tied", 32'(stall_cnt), 32'd0);
    chk("frame_cnt_tied", 32'(frame_cnt), 32'd0);
`endif

    step();
    chk("rd_q_drained", rd_q.size(), 32'd0);
    chk("pix_q_drained", pix_q.size(), 32'd0);
    chk("wr_q_drained", wr_q.size(), 32'd0);
    chk("swap_q_drained", sw_cyc_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
